// File: rtl/wash_pkg.sv
// rtl/wash_pkg.sv - phase codes, motor speeds and duration helper for the wash sequencer
package wash_pkg;

  typedef logic [2:0] phase_t;
  typedef logic [1:0] motor_t;

  localparam phase_t PH_IDLE    = 3'd0;
  localparam phase_t PH_FILL    = 3'd1;
  localparam phase_t PH_PREWASH = 3'd2;
  localparam phase_t PH_WASH    = 3'd3;
  localparam phase_t PH_RINSE   = 3'd4;
  localparam phase_t PH_SPIN    = 3'd5;
  localparam phase_t PH_DONE    = 3'd6;

  localparam motor_t MOTOR_OFF  = 2'b00;
  localparam motor_t MOTOR_SLOW = 2'b01;
  localparam motor_t MOTOR_FAST = 2'b10;

  // Truncate a duration to w bits; a zero duration still lasts one tick.
  function automatic int eff_ticks(input int d, input int w);
    longint m;
    m = longint'(d) & ((longint'(1) << w) - longint'(1));
    return (m == 0) ? 1 : int'(m);
  endfunction

endpackage

// File: rtl/tick_edge_detect.sv
// rtl/tick_edge_detect.sv - rising-edge detector turning the divider strobe S into one-cycle ticks
module tick_edge_detect (
  input  logic inpClk,
  input  logic reset,
  input  logic S,
  output logic tick
);

  logic s_d;

  // s_d resets to 0 so an S already high at reset release yields one tick.
  always_ff @(posedge inpClk or posedge reset) begin
    if (reset) s_d <= 1'b0;
    else       s_d <= S;
  end

  assign tick = S & ~s_d;

endmodule

// File: rtl/wash_sequencer.sv
// rtl/wash_sequencer.sv - tick-timed fill/wash/rinse/spin sequencer; WASH_PREWASH_EN adds a PREWASH phase
module wash_sequencer
  import wash_pkg::*;
#(
  parameter int TICK_W        = 8,
  parameter int FILL_TICKS    = 4,
  parameter int PREWASH_TICKS = 3,
  parameter int WASH_TICKS    = 10,
  parameter int RINSE_TICKS   = 6,
  parameter int SPIN_TICKS    = 5
) (
  input  logic              inpClk,
  input  logic              reset,
  input  logic              S,
  input  logic              start,
  input  logic              door_closed,
  input  logic              pause,
  output logic [2:0]        phase,
  output logic [TICK_W-1:0] remaining,
  output logic              valve,
  output logic [1:0]        motor,
  output logic              drain,
  output logic              busy,
  output logic              done
);

  localparam logic [TICK_W-1:0] FILL_D    = TICK_W'(eff_ticks(FILL_TICKS, TICK_W));
  localparam logic [TICK_W-1:0] PREWASH_D = TICK_W'(eff_ticks(PREWASH_TICKS, TICK_W));
  localparam logic [TICK_W-1:0] WASH_D    = TICK_W'(eff_ticks(WASH_TICKS, TICK_W));
  localparam logic [TICK_W-1:0] RINSE_D   = TICK_W'(eff_ticks(RINSE_TICKS, TICK_W));
  localparam logic [TICK_W-1:0] SPIN_D    = TICK_W'(eff_ticks(SPIN_TICKS, TICK_W));

  logic              tick;
  logic              hold;
  logic              running;
  phase_t            phase_nxt;
  logic [TICK_W-1:0] rem_nxt;

  tick_edge_detect u_tick (
    .inpClk (inpClk),
    .reset  (reset),
    .S      (S),
    .tick   (tick)
  );

  function automatic phase_t next_phase(input phase_t p);
    case (p)
`ifdef WASH_PREWASH_EN
      PH_FILL:    return PH_PREWASH;
`else
      PH_FILL:    return PH_WASH;
`endif
      PH_PREWASH: return PH_WASH;
      PH_WASH:    return PH_RINSE;
      PH_RINSE:   return PH_SPIN;
      PH_SPIN:    return PH_DONE;
      default:    return PH_IDLE;
    endcase
  endfunction

  function automatic logic [TICK_W-1:0] phase_dur(input phase_t p);
    case (p)
      PH_FILL:    return FILL_D;
      PH_PREWASH: return PREWASH_D;
      PH_WASH:    return WASH_D;
      PH_RINSE:   return RINSE_D;
      PH_SPIN:    return SPIN_D;
      default:    return '0;
    endcase
  endfunction

  assign hold    = pause | ~door_closed;
  assign running = (phase >= PH_FILL) && (phase <= PH_SPIN);
  assign busy    = running;
  assign done    = (phase == PH_DONE);

  always_comb begin
    phase_nxt = phase;
    rem_nxt   = remaining;
    if (phase == PH_IDLE) begin
      // A tick coinciding with an accepted start is deliberately not counted.
      if (start && door_closed) begin
        phase_nxt = PH_FILL;
        rem_nxt   = FILL_D;
      end
    end else if (running) begin
      if (tick && !hold) begin
        if (remaining > TICK_W'(1)) begin
          rem_nxt = remaining - TICK_W'(1);
        end else begin
          phase_nxt = next_phase(phase);
          rem_nxt   = phase_dur(phase_nxt);
        end
      end
    end else begin
      phase_nxt = PH_IDLE;
      rem_nxt   = '0;
    end
  end

  always_ff @(posedge inpClk or posedge reset) begin
    if (reset) begin
      phase     <= PH_IDLE;
      remaining <= '0;
    end else begin
      phase     <= phase_nxt;
      remaining <= rem_nxt;
    end
  end

  // Actuators are registered from the next phase so they never follow inputs combinationally.
  always_ff @(posedge inpClk or posedge reset) begin
    if (reset) begin
      valve <= 1'b0;
      motor <= MOTOR_OFF;
      drain <= 1'b0;
    end else if (hold) begin
      valve <= 1'b0;
      motor <= MOTOR_OFF;
      drain <= 1'b0;
    end else begin
      valve <= (phase_nxt == PH_FILL) || (phase_nxt == PH_RINSE);
      drain <= (phase_nxt == PH_SPIN);
      case (phase_nxt)
        PH_PREWASH, PH_WASH, PH_RINSE: motor <= MOTOR_SLOW;
        PH_SPIN:                       motor <= MOTOR_FAST;
        default:                       motor <= MOTOR_OFF;
      endcase
    end
  end

endmodule

// File: tb/tb_wash_sequencer.sv
// tb/tb_wash_sequencer.sv - randomized bench for wash_sequencer against a programme-list reference model
module tb_wash_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       S, start, door_closed, pause;
  logic [2:0] phase;
  logic [7:0] remaining;
  logic       valve, drain, busy, done;
  logic [1:0] motor;
  logic [2:0] z_phase;
  logic [7:0] z_remaining;
  logic       z_valve, z_drain, z_busy, z_done;
  logic [1:0] z_motor;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int prog_ph[$];
  int prog_dur[$];
  int m_idx, m_rem;
  bit m_prev_s, m_hold;

  always #5 clk = ~clk;

  wash_sequencer dut (
    .inpClk(clk), .reset(reset), .S(S), .start(start), .door_closed(door_closed),
    .pause(pause), .phase(phase), .remaining(remaining), .valve(valve), .motor(motor),
    .drain(drain), .busy(busy), .done(done)
  );

  wash_sequencer #(.FILL_TICKS(0)) u_zero (
    .inpClk(clk), .reset(reset), .S(S), .start(start), .door_closed(door_closed),
    .pause(pause), .phase(z_phase), .remaining(z_remaining), .valve(z_valve), .motor(z_motor),
    .drain(z_drain), .busy(z_busy), .done(z_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int clip(input int d);
    int m;
    m = d % 256;
    return (m == 0) ? 1 : m;
  endfunction

  function automatic int m_phase();
    if (m_idx < 0) return 0;
    if (m_idx >= prog_ph.size()) return 6;
    return prog_ph[m_idx];
  endfunction

  task automatic model_reset();
    m_idx = -1; m_rem = 0; m_prev_s = 0; m_hold = 0;
  endtask

  task automatic check_outputs();
    int  ph;
    bit  run;
    ph  = m_phase();
    run = (m_idx >= 0) && (m_idx < prog_ph.size());
    check("phase", 32'(phase), 32'(ph));
    check("remaining", 32'(remaining), run ? 32'(m_rem) : 32'd0);
    check("valve", 32'(valve), 32'(!m_hold && (ph == 1 || ph == 4)));
    check("motor", 32'(motor), m_hold ? 32'd0 : (ph == 2 || ph == 3 || ph == 4) ? 32'd1 : (ph == 5) ? 32'd2 : 32'd0);
    check("drain", 32'(drain), 32'(!m_hold && ph == 5));
    check("busy", 32'(busy), 32'(run));
    check("done", 32'(done), 32'(ph == 6));
  endtask

  task automatic step(input bit st, input bit dc, input bit pz, input bit s);
    bit tk;
    start = st; door_closed = dc; pause = pz; S = s;
    @(posedge clk); #1;
    cyc++;
    tk = s && !m_prev_s;
    m_prev_s = s;
    if (m_idx < 0) begin
      if (st && dc) begin m_idx = 0; m_rem = prog_dur[0]; end
    end else if (m_idx >= prog_ph.size()) begin
      m_idx = -1;
    end else if (tk && dc && !pz) begin
      if (m_rem > 1) m_rem--;
      else begin
        m_idx++;
        m_rem = (m_idx < prog_ph.size()) ? prog_dur[m_idx] : 0;
      end
    end
    m_hold = pz || !dc;
    check_outputs();
  endtask

  task automatic async_reset();
    #2 reset = 1'b1;
    #1 model_reset();
    check_outputs();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // S period of 8 cycles drives the programme until the model reaches target.
  task automatic run_until(input int target, input int budget);
    int k;
    k = 0;
    while (m_phase() != target && k < budget) begin
      step(1'b0, 1'b1, 1'b0, (cyc % 8) < 4);
      k++;
    end
    if (m_phase() != target) check("run_until_timeout", 32'(m_phase()), 32'(target));
  endtask

  initial begin
    int done_seen;
    bit saw7;
    prog_ph.push_back(1); prog_dur.push_back(clip(4));
`ifdef WASH_PREWASH_EN
    prog_ph.push_back(2); prog_dur.push_back(clip(3));
`endif
    prog_ph.push_back(3); prog_dur.push_back(clip(10));
    prog_ph.push_back(4); prog_dur.push_back(clip(6));
    prog_ph.push_back(5); prog_dur.push_back(clip(5));

    reset = 1'b1; S = 0; start = 0; door_closed = 0; pause = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_outputs();
    reset = 1'b0;

    step(1, 0, 0, 0);                         // start with door open is ignored
    step(1, 1, 0, 1);                         // tick on accepted start is not counted
    check("zero_fill_rem", 32'(z_remaining), 32'd1);
    step(0, 1, 0, 0);
    step(0, 1, 0, 1);
`ifdef WASH_PREWASH_EN
    check("zero_fill_next", 32'(z_phase), 32'd2);
    check("zero_fill_next_rem", 32'(z_remaining), 32'd3);
`else
    check("zero_fill_next", 32'(z_phase), 32'd3);
    check("zero_fill_next_rem", 32'(z_remaining), 32'd10);
`endif

    // Nominal run with door interlock and pause-on-tick excursions.
    saw7 = 0; done_seen = 0;
    for (int k = 0; k < 600 && m_idx >= 0; k++) begin
      if (!saw7 && m_phase() == 3 && m_rem == 7) begin
        saw7 = 1;
        for (int j = 0; j < 16; j++) begin
          step(0, 0, 0, (cyc % 8) < 4);
          check("door_rem_frozen", 32'(remaining), 32'd7);
          check("door_motor_off", 32'(motor), 32'd0);
        end
      end else if (k % 37 == 5) begin
        step(0, 1, 0, 0);
        step(0, 1, 1, 1);                     // pause coincident with rising S
        check("pause_all_off", 32'({valve, motor, drain}), 32'd0);
        step(0, 1, 1, 1);
        step(0, 1, 0, 0);
      end else begin
        step(0, 1, 0, (cyc % 8) < 4);
      end
      if (done) done_seen++;
    end
    check("nominal_done_pulses", 32'(done_seen), 32'd1);
    check("nominal_door_seen", 32'(saw7), 32'd1);

    // Start while busy, then reset mid-SPIN.
    step(1, 1, 0, 0);
    run_until(4, 400);
    step(1, 1, 0, 0);
    check("start_in_rinse", 32'(phase), 32'd4);
    run_until(5, 400);
    step(0, 1, 0, 0);
    async_reset();
    check("reset_drain", 32'(drain), 32'd0);
    step(1, 1, 0, 0);
    check("restart_rem", 32'(remaining), 32'd4);

    // Randomized phase with occasional asynchronous resets.
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 599) == 0) async_reset();
      else step($urandom_range(0, 9) == 0, $urandom_range(0, 15) != 0,
                $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
